// File: rtl/delay_stream_queue.sv
// Storage, read/write pointers and occupancy count for delay_stream.
// Pointers wrap modulo p_depth; the storage array itself is never reset.
module delay_stream_queue #(
  parameter int unsigned p_msg_bits = 32,
  parameter int unsigned p_depth    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [p_msg_bits-1:0]        wr_msg,
  input  logic                         rd_en,
  output logic [p_msg_bits-1:0]        rd_msg,
  output logic [$clog2(p_depth+1)-1:0] num_msgs,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned c_ptr_bits = $clog2(p_depth);
  localparam int unsigned c_cnt_bits = $clog2(p_depth + 1);
  localparam logic [c_cnt_bits-1:0] c_full_cnt = c_cnt_bits'(p_depth);

  logic [p_msg_bits-1:0] mem [p_depth];
  logic [c_ptr_bits-1:0] wr_ptr;
  logic [c_ptr_bits-1:0] rd_ptr;
  logic [c_cnt_bits-1:0] count;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_msg;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_msg   = mem[rd_ptr];
    num_msgs = count;
    full     = (count == c_full_cnt);
    empty    = (count == '0);
  end

endmodule

// File: rtl/delay_stream.sv
// Valid/ready message queue with a minimum interval between accepted sends.
// Optional same-cycle bypass of an empty queue: define DELAY_STREAM_BYPASS_EN.
module delay_stream #(
  parameter int unsigned p_msg_bits        = 32,
  parameter int unsigned p_send_intv_delay = 0,
  parameter int unsigned p_depth           = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         send_val,
  output logic                         send_rdy,
  input  logic [p_msg_bits-1:0]        send_msg,
  output logic                         recv_val,
  input  logic                         recv_rdy,
  output logic [p_msg_bits-1:0]        recv_msg,
  output logic [$clog2(p_depth+1)-1:0] num_msgs
);

  localparam int unsigned c_intv_bits =
    (p_send_intv_delay > 0) ? $clog2(p_send_intv_delay + 1) : 1;
  localparam logic [c_intv_bits-1:0] c_intv_load = c_intv_bits'(p_send_intv_delay);

  logic [c_intv_bits-1:0] intv_cnt;
  logic                   q_full;
  logic                   q_empty;
  logic [p_msg_bits-1:0]  q_msg;
  logic                   send_fire;
  logic                   bypass;
  logic                   q_wr;
  logic                   q_rd;

  // Reset is folded in so send_rdy reads low while rst is held.
  assign send_rdy  = rst & ~q_full & (intv_cnt == '0);
  assign send_fire = send_val & send_rdy;

`ifdef DELAY_STREAM_BYPASS_EN
  assign bypass = q_empty & send_val & send_rdy & recv_rdy;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    recv_val = ~q_empty | bypass;
    recv_msg = q_empty ? send_msg : q_msg;
    q_wr     = send_fire & ~bypass;
    q_rd     = ~q_empty & recv_rdy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intv_cnt <= '0;
    end else if (send_fire) begin
      intv_cnt <= c_intv_load;
    end else if (intv_cnt != '0) begin
      intv_cnt <= intv_cnt - 1'b1;
    end
  end

  delay_stream_queue #(
    .p_msg_bits (p_msg_bits),
    .p_depth    (p_depth)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (q_wr),
    .wr_msg   (send_msg),
    .rd_en    (q_rd),
    .rd_msg   (q_msg),
    .num_msgs (num_msgs),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_delay_stream.sv
// Directed self-checking bench for delay_stream: one instance with no send
// interval (streaming, full, wrap, bypass) and one with interval 2 (pacing, reset).
module tb_delay_stream;

`ifdef DELAY_STREAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;

  logic        a_send_val, a_send_rdy, a_recv_val, a_recv_rdy;
  logic [31:0] a_send_msg, a_recv_msg;
  logic [3:0]  a_num;

  logic        b_send_val, b_send_rdy, b_recv_val, b_recv_rdy;
  logic [31:0] b_send_msg, b_recv_msg;
  logic [3:0]  b_num;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delay_stream #(.p_msg_bits(32), .p_send_intv_delay(0), .p_depth(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .send_val(a_send_val), .send_rdy(a_send_rdy), .send_msg(a_send_msg),
    .recv_val(a_recv_val), .recv_rdy(a_recv_rdy), .recv_msg(a_recv_msg),
    .num_msgs(a_num)
  );

  delay_stream #(.p_msg_bits(32), .p_send_intv_delay(2), .p_depth(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .send_val(b_send_val), .send_rdy(b_send_rdy), .send_msg(b_send_msg),
    .recv_val(b_recv_val), .recv_rdy(b_recv_rdy), .recv_msg(b_recv_msg),
    .num_msgs(b_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] m, input logic r);
    a_send_val = v;
    a_send_msg = m;
    a_recv_rdy = r;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_send_val = 1'b1; a_send_msg = '0; a_recv_rdy = 1'b0;
    b_send_val = 1'b1; b_send_msg = '0; b_recv_rdy = 1'b0;
    #2;
    chk("reset_send_rdy", {31'd0, a_send_rdy}, 32'd0);
    chk("reset_recv_val", {31'd0, a_recv_val}, 32'd0);
    chk("reset_num",      {28'd0, a_num},      32'd0);
    chk("reset_b_send_rdy", {31'd0, b_send_rdy}, 32'd0);
    tick;
    a_send_val = 1'b0; b_send_val = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    tick;
    chk("post_reset_send_rdy", {31'd0, a_send_rdy}, 32'd1);

    // Streaming 0xA, 0xB, 0xC back to back
    drive_a(1'b1, 32'hA, 1'b1);
    chk("stream0_send_rdy", {31'd0, a_send_rdy}, 32'd1);
    chk("stream0_recv_val", {31'd0, a_recv_val}, BYP ? 32'd1 : 32'd0);
    tick;
    drive_a(1'b1, 32'hB, 1'b1);
    chk("stream1_send_rdy", {31'd0, a_send_rdy}, 32'd1);
    chk("stream1_recv_val", {31'd0, a_recv_val}, 32'd1);
    chk("stream1_recv_msg", a_recv_msg, BYP ? 32'hB : 32'hA);
    chk("stream1_num", {28'd0, a_num}, BYP ? 32'd0 : 32'd1);
    tick;
    drive_a(1'b1, 32'hC, 1'b1);
    chk("stream2_send_rdy", {31'd0, a_send_rdy}, 32'd1);
    chk("stream2_recv_msg", a_recv_msg, BYP ? 32'hC : 32'hB);
    tick;
    drive_a(1'b0, 32'h0, 1'b1);
    chk("stream3_recv_val", {31'd0, a_recv_val}, BYP ? 32'd0 : 32'd1);
    if (!BYP) chk("stream3_recv_msg", a_recv_msg, 32'hC);
    tick;
    drive_a(1'b0, 32'h0, 1'b0);
    chk("stream_drained", {31'd0, a_recv_val}, 32'd0);
    chk("stream_drained_num", {28'd0, a_num}, 32'd0);

    // Fill to depth 8 with the consumer stalled
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 32'h10 + i, 1'b0);
      chk($sformatf("fill%0d_send_rdy", i), {31'd0, a_send_rdy}, 32'd1);
      tick;
    end
    drive_a(1'b0, 32'h0, 1'b0);
    chk("full_num", {28'd0, a_num}, 32'd8);
    chk("full_send_rdy", {31'd0, a_send_rdy}, 32'd0);
    chk("full_recv_msg", a_recv_msg, 32'h10);
    drive_a(1'b1, 32'hEE, 1'b1);
    chk("full_no_passthru", {31'd0, a_send_rdy}, 32'd0);
    tick;
    drive_a(1'b0, 32'h0, 1'b0);
    chk("after_pop_num", {28'd0, a_num}, 32'd7);
    chk("after_pop_send_rdy", {31'd0, a_send_rdy}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      drive_a(1'b0, 32'h0, 1'b1);
      chk($sformatf("drain%0d_msg", i), a_recv_msg, 32'h10 + i);
      tick;
    end
    drive_a(1'b0, 32'h0, 1'b0);
    chk("drain_empty", {31'd0, a_recv_val}, 32'd0);

    // Wrap-around: keep 3 queued while streaming 0..19 through
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, i, 1'b0);
      tick;
    end
    for (int i = 3; i < 20; i++) begin
      drive_a(1'b1, i, 1'b1);
      chk($sformatf("wrap%0d_msg", i - 3), a_recv_msg, i - 3);
      chk($sformatf("wrap%0d_num", i - 3), {28'd0, a_num}, 32'd3);
      tick;
    end
    for (int i = 17; i < 20; i++) begin
      drive_a(1'b0, 32'h0, 1'b1);
      chk($sformatf("wrap%0d_msg", i), a_recv_msg, i);
      tick;
    end
    drive_a(1'b0, 32'h0, 1'b0);
    chk("wrap_empty_num", {28'd0, a_num}, 32'd0);

`ifdef DELAY_STREAM_BYPASS_EN
    drive_a(1'b1, 32'h5, 1'b1);
    chk("bypass_recv_val", {31'd0, a_recv_val}, 32'd1);
    chk("bypass_recv_msg", a_recv_msg, 32'h5);
    chk("bypass_num", {28'd0, a_num}, 32'd0);
    tick;
    drive_a(1'b0, 32'h0, 1'b0);
    chk("bypass_num_after", {28'd0, a_num}, 32'd0);
    chk("bypass_not_stored", {31'd0, a_recv_val}, 32'd0);
`endif

    // Send interval 2 with send_val held: accepts at cycles 0, 3, 6
    for (int c = 0; c < 7; c++) begin
      b_send_val = 1'b1;
      b_send_msg = 32'h20 + c;
      b_recv_rdy = 1'b0;
      #1;
      chk($sformatf("intv_c%0d_send_rdy", c), {31'd0, b_send_rdy},
          (c % 3 == 0) ? 32'd1 : 32'd0);
      tick;
    end
    b_send_val = 1'b0;
    tick;
    #1;
    chk("intv_num", {28'd0, b_num}, 32'd3);
    chk("intv_head", b_recv_msg, 32'h20);
    chk("intv_cnt_pending", {31'd0, b_send_rdy}, 32'd0);

    // Mid-stream reset with 3 queued and the interval counter at 1
    rst = 1'b0;
    #1;
    chk("midrst_recv_val", {31'd0, b_recv_val}, 32'd0);
    chk("midrst_num", {28'd0, b_num}, 32'd0);
    chk("midrst_send_rdy", {31'd0, b_send_rdy}, 32'd0);
    rst = 1'b1;
    #1;
    chk("release_send_rdy", {31'd0, b_send_rdy}, 32'd1);
    tick;
    chk("release_edge_send_rdy", {31'd0, b_send_rdy}, 32'd1);
    chk("release_num", {28'd0, b_num}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
